// File: rtl/led_pattern_engine.sv
// LED pattern engine: running dot, bounce, fill bar and checkerboard over N_LEDS
// outputs, stepped every BASE_DIV*(i_sw+1) cycles, with pause and a direction button.
module led_pattern_engine #(
    parameter int N_LEDS   = 8,
    parameter int BASE_DIV = 1_000_000,
    parameter int SPD_W    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [SPD_W-1:0]  i_sw,
    input  logic [1:0]        i_mode,
    input  logic              i_dir_btn,
    input  logic              i_pause,
    output logic [N_LEDS-1:0] o_led,
    output logic              o_step
);
    localparam int POS_W = $clog2(N_LEDS);
    localparam int LVL_W = $clog2(N_LEDS + 1);
    localparam int PSC_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_LEDS);
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(BASE_DIV - 1);

    typedef enum logic [1:0] {
        MODE_RUN    = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_CHECK  = 2'b11
    } mode_e;

    mode_e             mode_in;
    mode_e             mode_q;
    logic              btn_s1_q, btn_s2_q, btn_s3_q;
    logic [PSC_W-1:0]  psc_q, psc_d;
    logic [SPD_W-1:0]  stc_q, stc_d;
    logic [POS_W-1:0]  pos_q, pos_d, pos_v;
    logic [LVL_W-1:0]  lvl_q, lvl_d, lvl_v;
    logic              phase_q, phase_d, phase_v;
    logic              dir_q, dir_d, dir_tgl;
    logic              step_q, step_out_q;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              btn_edge, mode_chg, base_tick, step_fire;

    assign mode_in   = mode_e'(i_mode);
    assign btn_edge  = btn_s2_q & ~btn_s3_q;
    assign mode_chg  = (mode_q != mode_in);
    assign base_tick = (psc_q == PSC_MAX);
    assign step_fire = base_tick && (stc_q >= i_sw) && !i_pause && !mode_chg;
    // A button edge landing on a step must steer that same step.
    assign dir_tgl   = dir_q ^ btn_edge;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        psc_d   = psc_q;
        stc_d   = stc_q;
        pos_d   = pos_q;
        lvl_d   = lvl_q;
        phase_d = phase_q;
        dir_d   = dir_tgl;
        if (mode_chg) begin
            psc_d   = '0;
            stc_d   = '0;
            pos_d   = '0;
            lvl_d   = '0;
            phase_d = 1'b0;
        end else if (!i_pause) begin
            if (base_tick) begin
                psc_d = '0;
                stc_d = (stc_q >= i_sw) ? '0 : stc_q + 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
            end
            if (step_fire) begin
                case (mode_q)
                    MODE_RUN: begin
                        if (!dir_tgl) pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
                        else          pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
                    end
                    MODE_BOUNCE: begin
                        if (!dir_tgl) begin
                            if (pos_q == POS_MAX) begin
                                dir_d = 1'b1;
                                pos_d = POS_MAX - 1'b1;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b0;
                                pos_d = POS_W'(1);
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                    MODE_FILL: begin
                        if (!dir_tgl) lvl_d = (lvl_q == LVL_MAX) ? '0 : lvl_q + 1'b1;
                        else          lvl_d = (lvl_q == '0) ? LVL_MAX : lvl_q - 1'b1;
                    end
                    MODE_CHECK: phase_d = ~phase_q;
                endcase
            end
        end
    end

    // On a mode switch the display jumps straight to the new mode's starting pattern.
    assign pos_v   = mode_chg ? '0 : pos_q;
    assign lvl_v   = mode_chg ? '0 : lvl_q;
    assign phase_v = mode_chg ? 1'b0 : phase_q;

    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            case (mode_in)
                MODE_RUN, MODE_BOUNCE: led_d[i] = (pos_v == POS_W'(i));
                MODE_FILL:             led_d[i] = (LVL_W'(i) < lvl_v);
                MODE_CHECK:            led_d[i] = ((i % 2) == 0) ^ phase_v;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_s3_q   <= 1'b0;
            mode_q     <= MODE_RUN;
            psc_q      <= '0;
            stc_q      <= '0;
            pos_q      <= '0;
            lvl_q      <= '0;
            phase_q    <= 1'b0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            step_out_q <= 1'b0;
            led_q      <= '0;
        end else begin
            btn_s1_q   <= i_dir_btn;
            btn_s2_q   <= btn_s1_q;
            btn_s3_q   <= btn_s2_q;
            mode_q     <= mode_in;
            psc_q      <= psc_d;
            stc_q      <= stc_d;
            pos_q      <= pos_d;
            lvl_q      <= lvl_d;
            phase_q    <= phase_d;
            dir_q      <= dir_d;
            step_q     <= step_fire;
            step_out_q <= step_q;
            led_q      <= led_d;
        end
    end

    assign o_led  = led_q;
    assign o_step = step_out_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine (N_LEDS=8, BASE_DIV=4): table-driven step sequences
// plus hand-written sequences for button, pause, speed change and reset corners.
module tb_led_pattern_engine;
    localparam int BASE_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic [1:0] mode_sel;
    logic       dir_btn;
    logic       pause;
    logic [7:0] o_led;
    logic       o_step;

    led_pattern_engine #(.N_LEDS(8), .BASE_DIV(BASE_DIV), .SPD_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw), .i_mode(mode_sel),
        .i_dir_btn(dir_btn), .i_pause(pause), .o_led(o_led), .o_step(o_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] sw;
        logic [7:0] init;
        logic [7:0] led;
        int         period;
    } vec_t;

    typedef struct {
        logic [7:0] led;
        int         period;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] m, input logic [3:0] s, input logic [7:0] ini,
                       input logic [7:0] led, input int period);
        tbl.push_back('{m, s, ini, led, period});
    endtask

    task automatic expect_step(input logic [7:0] led, input int period);
        sb_q.push_back('{led, period});
    endtask

    // Pops each expected step, waits (bounded) for o_step and checks pattern and spacing.
    task automatic drain(input string tag);
        exp_t       e;
        int         cyc;
        bit         stable;
        logic [7:0] prev;
        while (sb_q.size() > 0) begin
            e      = sb_q.pop_front();
            prev   = o_led;
            cyc    = 0;
            stable = 1'b1;
            do begin
                @(negedge clk);
                cyc++;
                if (!o_step && (o_led !== prev)) stable = 1'b0;
            end while (!o_step && cyc < 400);
            check({tag, " led"}, 32'(o_led), 32'(e.led));
            check({tag, " period"}, cyc, e.period);
            check({tag, " led held between steps"}, 32'(stable), 32'd1);
        end
    endtask

    initial begin
        int         bpos[15];
        int         lv;
        int         steps_seen;
        int         led_moved;
        logic [1:0] cur_mode;
        logic [7:0] exp_led;

        bpos = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        for (int k = 1; k <= 8; k++) add(2'b00, 4'd0, 8'h00, 8'(1 << (k % 8)), 4);
        add(2'b00, 4'd3, 8'h00, 8'h02, 16);
        add(2'b00, 4'd3, 8'h00, 8'h04, 16);
        for (int k = 0; k < 15; k++) add(2'b01, 4'd0, 8'h01, 8'(1 << bpos[k]), (k == 0) ? 5 : 4);
        for (int k = 0; k < 11; k++) begin
            lv = (k < 8) ? k + 1 : k - 8;
            add(2'b10, 4'd0, 8'h00, 8'((1 << lv) - 1), (k == 0) ? 5 : 4);
        end

        rst_n    = 1'b1;
        sw       = 4'd0;
        mode_sel = 2'b00;
        dir_btn  = 1'b0;
        pause    = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset led", 32'(o_led), 32'h00);
        check("reset step", 32'(o_step), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first pattern after reset", 32'(o_led), 32'h01);

        cur_mode = 2'b00;
        foreach (tbl[i]) begin
            if (tbl[i].mode != cur_mode) begin
                mode_sel = tbl[i].mode;
                sw       = tbl[i].sw;
                cur_mode = tbl[i].mode;
                @(negedge clk);
                check($sformatf("tbl[%0d] mode start pattern", i), 32'(o_led), 32'(tbl[i].init));
            end else begin
                sw = tbl[i].sw;
            end
            expect_step(tbl[i].led, tbl[i].period);
            drain($sformatf("tbl[%0d]", i));
        end

        // Fill at level 2: button edge lands on the next step, so it already counts down.
        dir_btn = 1'b1;
        expect_step(8'h01, 4);
        expect_step(8'h00, 4);
        expect_step(8'hFF, 4);
        expect_step(8'h7F, 4);
        drain("fill down");
        dir_btn = 1'b0;
        expect_step(8'h3F, 4);
        drain("fill release");
        dir_btn = 1'b1;
        expect_step(8'h7F, 4);
        drain("fill back up");

        dir_btn  = 1'b0;
        mode_sel = 2'b00;
        @(negedge clk);
        check("running start pattern", 32'(o_led), 32'h01);
        expect_step(8'h02, 5);
        expect_step(8'h04, 4);
        expect_step(8'h08, 4);
        expect_step(8'h10, 4);
        drain("running up");

        // Button edge coincides with the step out of 10; held for 25 steps, one toggle only.
        dir_btn = 1'b1;
        exp_led = 8'h10;
        for (int k = 0; k < 25; k++) begin
            exp_led = {exp_led[0], exp_led[7:1]};
            expect_step(exp_led, 4);
        end
        drain("button held");
        dir_btn = 1'b0;
        expect_step(8'h04, 4);
        expect_step(8'h02, 4);
        drain("button released");

        // Lowering i_sw mid-count steps on the very next base tick.
        sw = 4'd3;
        expect_step(8'h01, 16);
        drain("sw3");
        steps_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_step) steps_seen++;
        end
        check("no step before sw lowered", steps_seen, 0);
        sw = 4'd1;
        expect_step(8'h80, 4);
        drain("sw lowered");
        expect_step(8'h40, 8);
        drain("sw1");

        sw         = 4'd0;
        pause      = 1'b1;
        steps_seen = 0;
        led_moved  = 0;
        repeat (50) begin
            @(negedge clk);
            if (o_step) steps_seen++;
            if (o_led !== 8'h40) led_moved++;
        end
        check("steps while paused", steps_seen, 0);
        check("led changes while paused", led_moved, 0);
        pause = 1'b0;
        expect_step(8'h20, 4);
        expect_step(8'h10, 4);
        drain("after pause");

        mode_sel = 2'b11;
        @(negedge clk);
        check("checker start pattern", 32'(o_led), 32'h55);
        expect_step(8'hAA, 5);
        expect_step(8'h55, 4);
        expect_step(8'hAA, 4);
        drain("checker");

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset led", 32'(o_led), 32'h00);
        check("async reset step", 32'(o_step), 32'd0);
        mode_sel = 2'b00;
        sw       = 4'd1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("pattern after async reset", 32'(o_led), 32'h01);
        expect_step(8'h02, 8);
        expect_step(8'h04, 8);
        drain("after reset sw1");

        // Button held high through reset gives one edge after release.
        rst_n   = 1'b0;
        dir_btn = 1'b1;
        sw      = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("pattern after reset with button", 32'(o_led), 32'h01);
        expect_step(8'h80, 4);
        expect_step(8'h40, 4);
        drain("button through reset");
        dir_btn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern generator, the successor to the fixed 8-LED running light. It covers N LEDs and four pattern modes: running dot, bounce, fill bar and checkerboard. It also provides switch-selected step rate, a pause input and an internally synchronised direction button. It sits in the board top level after the PLL, in place of the separate divider, edge-detector and driver blocks.

## Interface
Parameters:
- N_LEDS, 8, number of LEDs; legal values are 2..32.
- BASE_DIV, 1_000_000, clock cycles per base tick; must be ≥1.
- SPD_W, 4, width of the speed-select input.

Ports:
- i_clk  in  1  system clock (PLL output); the only clock.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_sw  in  SPD_W  speed select; step period is BASE_DIV*(i_sw+1) cycles.
- i_mode  in  2  pattern mode: 00 running, 01 bounce, 10 fill, 11 checker.
- i_dir_btn  in  1  raw asynchronous direction button, active-high; each rising edge toggles direction.
- i_pause  in  1  high freezes pattern and rate counters.
- o_led  out  N_LEDS  registered LED pattern.
- o_step  out  1  one-cycle pulse, asserted in the first cycle a new pattern appears on o_led.

## Operation
- Rate generation:
  - The prescaler counts 0..BASE_DIV-1. A base tick occurs when the count equals BASE_DIV-1, and the prescaler then returns to 0.
  - The step counter increments on each base tick.
  - A step fires on a base tick when the step counter is ≥ i_sw; the step counter then clears. Using ≥ means that lowering i_sw mid-count steps on the next base tick.
- Direction:
  - i_dir_btn passes through a 2-flop synchroniser and a rising-edge detector.
  - The dir register toggles on each detected edge: 0 = up (toward the MSB), 1 = down.
  - Edges are honoured even while paused.
- State:
  - pos: clog2(N_LEDS) bits.
  - level: clog2(N_LEDS+1) bits.
  - phase: 1 bit.
  - dir: 1 bit.
- Mode behaviour on a step:
  - 00 running: pos moves ±1 modulo N_LEDS, so it wraps at both ends. o_led = 1<<pos.
  - 01 bounce: pos moves ±1.
    - At pos=N_LEDS-1 with dir up, dir becomes down and pos becomes N_LEDS-2.
    - At pos=0 with dir down, dir becomes up and pos becomes 1.
    - End LEDs are therefore shown for exactly one step. o_led = 1<<pos.
  - 10 fill: level moves ±1. Moving up from N_LEDS wraps to 0; moving down from 0 wraps to N_LEDS. o_led = (1<<level)-1, i.e. the low `level` bits are set.
  - 11 checker: phase toggles each step. o_led = 0101…01 (bit0 set) when phase=0 and the complement when phase=1. dir has no effect.
- Simultaneous button edge and step: dir toggles first, and the step uses the new dir, including the bounce reflection check.
- Mode change:
  - i_mode is registered. When the registered mode differs from i_mode, pos, level, phase, the prescaler and the step counter all clear the next cycle. dir is kept.
  - Any step that fires in the same cycle is discarded.
- Pause: while i_pause=1, the prescaler, step counter and pattern state hold, and o_step stays 0.
- Reset (asynchronous, any time):
  - o_led=0, o_step=0, dir=0.
  - pos, level, phase and all counters go to 0.
  - Synchroniser flops go to 0, so a button held high through reset produces one edge after release.

## Timing
- o_led is a register fed from the state. It shows the new pattern one cycle after the state update.
- The first cycle after reset release shows the mode's initial pattern: 00/01 → bit0 only, 10 → all zero, 11 → 0101…01.
- Step latency:
  - A step fired at clock edge k updates the state at edge k.
  - o_led and o_step change at edge k+1.
  - o_step is high for exactly one cycle.
- Step period: exactly BASE_DIV*(i_sw+1) cycles when i_sw is static. The first step after reset or a mode change occurs at the same period, measured from the clearing of the counters.
- Button latency: dir toggles on the 3rd rising edge after i_dir_btn rises (2 synchroniser flops plus the edge register). It affects o_led no earlier than the next step.
- Holding or releasing the button produces no further toggles; only rising edges count.

## Test plan
- Running mode, N_LEDS=8, BASE_DIV=4, i_sw=0:
  - o_led sequence is 01,02,04,…,80,01, with one change every 4 cycles.
  - o_step pulses are aligned with each change.
  - With i_sw=3, changes occur every 16 cycles.
- Bounce mode, from reset: o_led sequence is 01,02,…,40,80,40,…,02,01,02. 80 and 01 each last one step, and dir flips exactly at the ends.
- Fill mode: o_led sequence is 00,01,03,07,…,FF,00. After a button edge, the sequence goes down, e.g. 03,01,00,FF,7F.
- Direction edge coinciding with a step, in running mode at 10: next o_led = 08. A button held high for 100 cycles toggles dir only once.
- Pause and mode change:
  - i_pause held for 50 cycles freezes o_led with no o_step pulses. Counting resumes from the frozen count.
  - Switching to checker gives 55 next, then AA,55 every step.
- Asynchronous reset asserted mid-step:
  - o_led=00 immediately, with no clock needed.
  - After release, o_led=01 next cycle, and the first step follows after exactly BASE_DIV*(i_sw+1) cycles.
